// File: rtl/axi4_rd_burst_checker.sv
// Passive AXI4 read-channel checker: tracks outstanding AR bursts in order and
// flags R-channel ID, beat-count, RLAST and stall violations.
module axi4_rd_burst_checker #(
  parameter int IDSIZE    = 4,
  parameter int LSIZE     = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_CYCLE = 1000
) (
  input  logic                         axi_aclk,
  input  logic                         axi_areset,
  input  logic                         axi_arvalid,
  input  logic                         axi_arready,
  input  logic [IDSIZE-1:0]            axi_arid,
  input  logic [LSIZE-1:0]             axi_arlen,
  input  logic                         axi_rvalid,
  input  logic                         axi_rready,
  input  logic [IDSIZE-1:0]            axi_rid,
  input  logic                         axi_rlast,
  input  logic                         err_clr,
  output logic [5:0]                   err_flags,
  output logic [2:0]                   err_first,
  output logic                         err_pulse,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic [31:0]                  burst_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [IDSIZE-1:0] id_mem_q  [DEPTH];
  logic [LSIZE-1:0]  len_mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LSIZE:0]    beat_cnt_q, beat_cnt_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic [5:0]        flags_q, flags_d;
  logic [2:0]        first_q, first_d;
  logic              pulse_q, pulse_d;
  logic [31:0]       done_q, done_d;

  logic              ar_hs, r_hs, empty, full, pop, push_ok;
  logic [IDSIZE-1:0] head_id;
  logic [LSIZE-1:0]  head_len;
  logic [5:0]        ev;
  logic [2:0]        ev_code;

  // A transfer happens only in a cycle where both valid and ready are high;
  // valid without ready (or ready without valid) is ignored entirely.
  always_comb begin
    ar_hs    = axi_arvalid & axi_arready;
    r_hs     = axi_rvalid & axi_rready;
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    head_id  = id_mem_q[rd_ptr_q];
    head_len = len_mem_q[rd_ptr_q];
    pop      = r_hs & axi_rlast & ~empty;
    push_ok  = ar_hs & (~full | pop);

    ev    = '0;
    ev[0] = ar_hs & full & ~pop;
    ev[1] = r_hs & empty;
    ev[2] = r_hs & ~empty & (axi_rid != head_id);
    ev[3] = pop & (beat_cnt_q < {1'b0, head_len});
    ev[4] = r_hs & ~empty & ~axi_rlast & (beat_cnt_q >= {1'b0, head_len});
    ev[5] = (stall_cnt_q == 16'(MAX_CYCLE));

    ev_code = '0;
    for (int i = 5; i >= 0; i--) begin
      if (ev[i]) ev_code = 3'(i + 1);
    end
  end

  always_comb begin
    wr_ptr_d    = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    beat_cnt_d = beat_cnt_q;
    if (pop)                                  beat_cnt_d = '0;
    else if (r_hs && !empty && !(&beat_cnt_q)) beat_cnt_d = beat_cnt_q + 1'b1;

    // Counter rests at zero while idle, so reaching the limit fires exactly once per stall.
    stall_cnt_d = stall_cnt_q;
    if (empty || r_hs)          stall_cnt_d = '0;
    else if (!(&stall_cnt_q))   stall_cnt_d = stall_cnt_q + 16'd1;

    flags_d = (err_clr ? 6'd0 : flags_q) | ev;
    first_d = err_clr ? ev_code : ((first_q == 3'd0) ? ev_code : first_q);
    pulse_d = |ev;
    done_d  = pop ? done_q + 32'd1 : done_q;
  end

  always_ff @(posedge axi_aclk) begin
    if (push_ok) begin
      id_mem_q[wr_ptr_q]  <= axi_arid;
      len_mem_q[wr_ptr_q] <= axi_arlen;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flags_q     <= '0;
      first_q     <= '0;
      pulse_q     <= 1'b0;
      done_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flags_q     <= flags_d;
      first_q     <= first_d;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
    end
  end

  assign err_flags   = flags_q;
  assign err_first   = first_q;
  assign err_pulse   = pulse_q;
  assign outstanding = count_q;
  assign burst_done  = done_q;

endmodule

// File: tb/tb_axi4_rd_burst_checker.sv
// Self-checking bench for axi4_rd_burst_checker (DEPTH=16, MAX_CYCLE=1000).
module tb_axi4_rd_burst_checker;
  localparam int W = 23;

  logic       clk = 1'b0;
  logic       areset;
  logic       arvalid, arready, rvalid, rready, rlast, clr;
  logic [3:0] arid, rid;
  logic [7:0] arlen;
  logic [5:0] err_flags;
  logic [2:0] err_first;
  logic       err_pulse;
  logic [4:0] outstanding;
  logic [31:0] burst_done;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  int n_cmp = 0;
  int n_mis = 0;

  axi4_rd_burst_checker #(.IDSIZE(4), .LSIZE(8), .DEPTH(16), .MAX_CYCLE(1000)) dut (
    .axi_aclk(clk), .axi_areset(areset),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_arid(arid), .axi_arlen(arlen),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rid(rid), .axi_rlast(rlast),
    .err_clr(clr), .err_flags(err_flags), .err_first(err_first), .err_pulse(err_pulse),
    .outstanding(outstanding), .burst_done(burst_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] obs();
    return {err_flags, err_first, err_pulse, outstanding, burst_done[7:0]};
  endfunction

  function automatic logic [W-1:0] mk(input logic [5:0] f, input logic [2:0] c,
                                      input logic p, input logic [4:0] o, input logic [7:0] b);
    return {f, c, p, o, b};
  endfunction

  // driver: idle channels carry random valid/payload with ready low (no handshake)
  task automatic drive(input logic arv, input logic [3:0] a_id, input logic [7:0] a_len,
                       input logic rv, input logic [3:0] r_id, input logic r_last, input logic c);
    if (arv) begin
      arvalid = 1'b1; arready = 1'b1; arid = a_id; arlen = a_len;
    end else begin
      arvalid = 1'($urandom_range(0, 1)); arready = 1'b0;
      arid = 4'($urandom_range(0, 15)); arlen = 8'($urandom_range(0, 255));
    end
    if (rv) begin
      rvalid = 1'b1; rready = 1'b1; rid = r_id; rlast = r_last;
    end else begin
      rvalid = 1'($urandom_range(0, 1)); rready = 1'b0;
      rid = 4'($urandom_range(0, 15)); rlast = 1'($urandom_range(0, 1));
    end
    clr = c;
    @(negedge clk);
  endtask

  task automatic idle(input logic c);
    drive(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0, c);
  endtask

  task automatic ar(input logic [3:0] a_id, input logic [7:0] a_len);
    drive(1'b1, a_id, a_len, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic rb(input logic [3:0] r_id, input logic r_last);
    drive(1'b0, 4'd0, 8'd0, 1'b1, r_id, r_last, 1'b0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    idle(1'b0);
    areset = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    idle(1'b0);
    idle(1'b0);
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd0, 8'd0));
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL reset: got %h exp %h", obs(), e); end
    areset = 1'b0;
  endtask

  task automatic test_clean_burst();
    do_reset();
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd1, 8'd0));
    ar(4'd3, 8'd3);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL clean_ar: got %h exp %h", obs(), e); end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i == 3) ? mk(6'd0, 3'd0, 1'b0, 5'd0, 8'd1) : mk(6'd0, 3'd0, 1'b0, 5'd1, 8'd0));
      rb(4'd3, i == 3);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e) begin n_mis++; $display("FAIL clean_beat%0d: got %h exp %h", i, obs(), e); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'(i + 1), 8'd0));
      ar(4'(i), 8'd0);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e) begin n_mis++; $display("FAIL fill%0d: got %h exp %h", i, obs(), e); end
    end
    exp_q.push_back(mk(6'b000001, 3'd1, 1'b1, 5'd16, 8'd0));
    ar(4'd9, 8'd0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL overflow: got %h exp %h", obs(), e); end
    exp_q.push_back(mk(6'b000001, 3'd1, 1'b0, 5'd16, 8'd0));
    idle(1'b0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL overflow_sticky: got %h exp %h", obs(), e); end
  endtask

  task automatic test_early_last();
    do_reset();
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd1, 8'd0));
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd1, 8'd0));
    exp_q.push_back(mk(6'b001000, 3'd4, 1'b1, 5'd0, 8'd1));
    exp_q.push_back(mk(6'b001010, 3'd4, 1'b1, 5'd0, 8'd1));
    exp_q.push_back(mk(6'b001010, 3'd4, 1'b1, 5'd0, 8'd1));
    for (int i = 0; i < 5; i++) begin
      if (i == 0) ar(4'd1, 8'd3);
      else        rb(4'd1, i == 2 || i == 4);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e) begin n_mis++; $display("FAIL early_step%0d: got %h exp %h", i, obs(), e); end
    end
  endtask

  task automatic test_wrong_id();
    do_reset();
    ar(4'd2, 8'd0);
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd2, 8'd0));
    ar(4'd5, 8'd0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL wid_ar: got %h exp %h", obs(), e); end
    exp_q.push_back(mk(6'b000100, 3'd3, 1'b1, 5'd1, 8'd1));
    rb(4'd5, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL wrong_id: got %h exp %h", obs(), e); end
    exp_q.push_back(mk(6'b000100, 3'd3, 1'b0, 5'd0, 8'd2));
    rb(4'd5, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL wid_next_head: got %h exp %h", obs(), e); end
  endtask

  task automatic test_missing_last();
    do_reset();
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd1, 8'd0));
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd1, 8'd0));
    exp_q.push_back(mk(6'b010000, 3'd5, 1'b1, 5'd1, 8'd0));
    exp_q.push_back(mk(6'b010000, 3'd5, 1'b1, 5'd1, 8'd0));
    exp_q.push_back(mk(6'b010000, 3'd5, 1'b0, 5'd0, 8'd1));
    for (int i = 0; i < 5; i++) begin
      if (i == 0) ar(4'd4, 8'd1);
      else        rb(4'd4, i == 4);
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e) begin n_mis++; $display("FAIL missing_step%0d: got %h exp %h", i, obs(), e); end
    end
  endtask

  task automatic test_timeout();
    int hit_k;
    do_reset();
    hit_k = 0;
    drive(1'b1, 4'd6, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 1100; k++) begin
      idle(1'b1);
      if (err_flags[5]) begin hit_k = k; break; end
    end
    n_cmp++;
    if (hit_k != 1001) begin n_mis++; $display("FAIL timeout_cycle: got %0d exp 1001", hit_k); end
    exp_q.push_back(mk(6'b100000, 3'd6, 1'b1, 5'd1, 8'd0));
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL timeout_vs_clr: got %h exp %h", obs(), e); end
    exp_q.push_back(mk(6'b100000, 3'd6, 1'b0, 5'd1, 8'd0));
    idle(1'b0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL timeout_sticky: got %h exp %h", obs(), e); end
    begin
      int pulses = 0;
      for (int k = 0; k < 50; k++) begin
        idle(1'b0);
        if (err_pulse) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin n_mis++; $display("FAIL timeout_once: got %0d pulses exp 0", pulses); end
    end
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd1, 8'd0));
    idle(1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL err_clr: got %h exp %h", obs(), e); end
  endtask

  task automatic test_full_push_pop_and_reset();
    do_reset();
    for (int i = 0; i < 16; i++) ar(4'(i), 8'd0);
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd16, 8'd1));
    drive(1'b1, 4'd7, 8'd0, 1'b1, 4'd0, 1'b1, 1'b0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL full_push_pop: got %h exp %h", obs(), e); end
    for (int i = 1; i < 16; i++) rb(4'(i), 1'b1);
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd0, 8'd17));
    rb(4'd7, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL full_drain: got %h exp %h", obs(), e); end
    ar(4'd3, 8'd2);
    rb(4'd3, 1'b0);
    areset = 1'b1;
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'd0, 8'd0));
    drive(1'b1, 4'd3, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e || burst_done !== 32'd0) begin n_mis++; $display("FAIL mid_reset: got %h exp %h", obs(), e); end
    areset = 1'b0;
    exp_q.push_back(mk(6'b000010, 3'd2, 1'b1, 5'd0, 8'd0));
    rb(4'd3, 1'b1);
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL post_reset_r: got %h exp %h", obs(), e); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] arq[$];
    logic [11:0] cmd;
    int n, done;
    do_reset();
    n = $urandom_range(4, 8);
    done = 0;
    for (int i = 0; i < n; i++) begin
      cmd = {4'($urandom_range(0, 15)), 8'($urandom_range(0, 5))};
      arq.push_back(cmd);
      ar(cmd[11:8], cmd[7:0]);
    end
    exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'(n), 8'd0));
    e = exp_q.pop_front(); n_cmp++;
    if (obs() !== e) begin n_mis++; $display("FAIL b2b_loaded: got %h exp %h", obs(), e); end
    while (arq.size() > 0) begin
      cmd = arq.pop_front();
      for (int b = 0; b <= int'(cmd[7:0]); b++) begin
        if ($urandom_range(0, 3) == 0) idle(1'b0);
        rb(cmd[11:8], b == int'(cmd[7:0]));
      end
      done++;
      exp_q.push_back(mk(6'd0, 3'd0, 1'b0, 5'(n - done), 8'(done)));
      e = exp_q.pop_front(); n_cmp++;
      if (obs() !== e) begin n_mis++; $display("FAIL b2b_burst%0d: got %h exp %h", done, obs(), e); end
    end
  endtask

  initial begin
    areset = 1'b1;
    arvalid = 1'b0; arready = 1'b0; arid = '0; arlen = '0;
    rvalid = 1'b0; rready = 1'b0; rid = '0; rlast = 1'b0; clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_burst();
    test_overflow();
    test_early_last();
    test_wrong_id();
    test_missing_last();
    test_timeout();
    test_full_push_pop_and_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
